multi_cycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath: one ALU, one unified memory, the IR/OldPC/Data/ALUOut registers and the register file. It walks each instruction through fetch, decode, execute, memory and writeback states. It drives the mux selects, the write enables and the 2-bit `ALUOp` consumed by the ALU controller.

---
 rtl/multi_cycle_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_controller
//  Purpose  : Main control FSM of the multi-cycle RV32I core. It sequences the
//             shared ALU, unified memory, IR/OldPC/Data/ALUOut registers and
//             the register file through fetch/decode/execute/memory/writeback.
//  Revision : 1.0  initial release
// ============================================================================
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       instrDone,
  output logic       illegal
);

  localparam logic [3:0] c_ST_RST      = 4'd0;
  localparam logic [3:0] c_ST_FETCH    = 4'd1;
  localparam logic [3:0] c_ST_DECODE   = 4'd2;
  localparam logic [3:0] c_ST_MEMADR   = 4'd3;
  localparam logic [3:0] c_ST_MEMREAD  = 4'd4;
  localparam logic [3:0] c_ST_MEMWB    = 4'd5;
  localparam logic [3:0] c_ST_MEMWRITE = 4'd6;
  localparam logic [3:0] c_ST_EXECR    = 4'd7;
  localparam logic [3:0] c_ST_EXECI    = 4'd8;
  localparam logic [3:0] c_ST_ALUWB    = 4'd9;
  localparam logic [3:0] c_ST_BRANCH   = 4'd10;
  localparam logic [3:0] c_ST_JALRADR  = 4'd11;
  localparam logic [3:0] c_ST_JAL      = 4'd12;
  localparam logic [3:0] c_ST_LUI      = 4'd13;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_taken;
  logic       w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      c_OP_LOAD, c_OP_STORE, c_OP_RTYPE, c_OP_ITYPE,
      c_OP_BRANCH, c_OP_JAL, c_OP_JALR, c_OP_LUI: w_legal = 1'b1;
      default:                                    w_legal = 1'b0;
    endcase
  end

  // Unsupported branch conditions simply fall through as not taken.
  always_comb begin
    w_taken = 1'b0;
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = c_ST_RST;
    case (r_state)
      c_ST_RST:      w_next = c_ST_FETCH;
      c_ST_FETCH:    w_next = c_ST_DECODE;
      c_ST_DECODE: begin
        case (opcode)
          c_OP_LOAD, c_OP_STORE: w_next = c_ST_MEMADR;
          c_OP_RTYPE:            w_next = c_ST_EXECR;
          c_OP_ITYPE:            w_next = c_ST_EXECI;
          c_OP_BRANCH:           w_next = c_ST_BRANCH;
          c_OP_JAL:              w_next = c_ST_JAL;
          c_OP_JALR:             w_next = c_ST_JALRADR;
          c_OP_LUI:              w_next = c_ST_LUI;
          default:               w_next = c_ST_FETCH;
        endcase
      end
      c_ST_MEMADR:   w_next = (opcode == c_OP_LOAD) ? c_ST_MEMREAD : c_ST_MEMWRITE;
      c_ST_MEMREAD:  w_next = c_ST_MEMWB;
      c_ST_MEMWB:    w_next = c_ST_FETCH;
      c_ST_MEMWRITE: w_next = c_ST_FETCH;
      c_ST_EXECR:    w_next = c_ST_ALUWB;
      c_ST_EXECI:    w_next = c_ST_ALUWB;
      c_ST_ALUWB:    w_next = c_ST_FETCH;
      c_ST_BRANCH:   w_next = c_ST_FETCH;
      c_ST_JALRADR:  w_next = c_ST_JAL;
      c_ST_JAL:      w_next = c_ST_ALUWB;
      c_ST_LUI:      w_next = c_ST_FETCH;
      default:       w_next = c_ST_RST;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    instrDone = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      c_ST_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      c_ST_DECODE: begin
        // ALUOut captures OldPC+imm so branch/JAL targets are ready later.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = ~w_legal;
      end
      c_ST_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_ST_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      c_ST_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      c_ST_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        instrDone = 1'b1;
      end
      c_ST_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      c_ST_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      c_ST_ALUWB: begin
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      c_ST_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        PCWrite   = w_taken;
        instrDone = 1'b1;
      end
      c_ST_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_ST_JAL: begin
        // PC takes the ALUOut target while ALUOut is refilled with OldPC+4.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      c_ST_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Immediate format follows the opcode directly; held at 0 while in reset.
  always_comb begin
    ImmSrc = c_IMM_I;
    if (r_state != c_ST_RST) begin
      case (opcode)
        c_OP_LOAD, c_OP_ITYPE, c_OP_JALR: ImmSrc = c_IMM_I;
        c_OP_STORE:                       ImmSrc = c_IMM_S;
        c_OP_BRANCH:                      ImmSrc = c_IMM_B;
        c_OP_JAL:                         ImmSrc = c_IMM_J;
        c_OP_LUI:                         ImmSrc = c_IMM_U;
        default:                          ImmSrc = 3'b000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cycle_controller
//  Purpose  : Self-checking bench: per-instruction output plan vs the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm;
    logic       done, ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instrDone, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instrDone(instrDone), .illegal(illegal)
  );

  outs_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, ImmSrc, instrDone, illegal};

  int    tests = 0;
  int    fails = 0;
  bit    chk = 1'b0;
  outs_t exp_o = '0;
  int    mw_pulses = 0;
  outs_t plan[$];
  bit    plan_br[$];

  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (act !== exp_o) begin
        fails++;
        $display("FAIL outputs t=%0t op=%b f3=%b z=%b n=%b act=%b exp=%b (pcw,adr,mw,irw,rw,rs,sa,sb,aop,imm,done,ill)",
                 $time, opcode, func3, zero, neg, act, exp_o);
      end
      tests++;
      if ($countones({RegWrite, MemWrite, IRWrite}) > 1) begin
        fails++;
        $display("FAIL write_exclusive t=%0t act=%b%b%b required at most one", $time,
                 RegWrite, MemWrite, IRWrite);
      end
      if (MemWrite === 1'b1) mw_pulses++;
    end
  end

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return ~z;
      3'b100:  return n;
      3'b101:  return ~n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t mk(input logic pcw, adr, mw, irw, rw,
                               input logic [1:0] rs, sa, sb, aop,
                               input logic done, ill);
    outs_t o;
    o = {pcw, adr, mw, irw, rw, rs, sa, sb, aop, 3'b000, done, ill};
    return o;
  endfunction

  function automatic void push(input outs_t o, input bit br);
    plan.push_back(o);
    plan_br.push_back(br);
  endfunction

  // Cycle-by-cycle outputs one instruction must produce, from the opcode alone.
  function automatic void build(input logic [6:0] op);
    bit legal;
    outs_t fetch_o, memadr_o, aluwb_o, jal_o;
    plan.delete();
    plan_br.delete();
    legal    = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    fetch_o  = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    memadr_o = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    aluwb_o  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    jal_o    = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    push(fetch_o, 0);
    push(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, !legal), 0);
    case (op)
      7'b0000011: begin
        push(memadr_o, 0);
        push(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), 0);
        push(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0), 0);
      end
      7'b0100011: begin
        push(memadr_o, 0);
        push(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), 0);
      end
      7'b0110011: begin
        push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0), 0);
        push(aluwb_o, 0);
      end
      7'b0010011: begin
        push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, 0, 0), 0);
        push(aluwb_o, 0);
      end
      7'b1100011: push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0), 1);
      7'b1101111: begin
        push(jal_o, 0);
        push(aluwb_o, 0);
      end
      7'b1100111: begin
        push(memadr_o, 0);
        push(jal_o, 0);
        push(aluwb_o, 0);
      end
      7'b0110111: push(mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0), 0);
      default: begin
      end
    endcase
  endfunction

  task automatic next_cycle(input bit force_zn, input logic zv, input logic nv);
    @(posedge clk);
    #1;
    if (force_zn) begin
      zero = zv;
      neg  = nv;
    end else begin
      zero = 1'($urandom);
      neg  = 1'($urandom);
    end
  endtask

  // Raise rst in the current cycle (if not already), keep it for n edges.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 1; i <= n; i++) begin
      next_cycle(0, 0, 0);
      if (i == n) rst = 1'b0;
      exp_o = '0;
      chk   = 1'b1;
    end
  endtask

  // abort >= 0 raises rst during that step; returns 1 if the instruction was cut.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int abort,
                           input bit force_zn, input logic zv, input logic nv,
                           output bit aborted);
    outs_t e;
    aborted = 1'b0;
    build(op);
    for (int j = 0; j < plan.size(); j++) begin
      next_cycle(force_zn, zv, nv);
      if (j == 0) begin
        opcode = op;
        func3  = f3;
      end
      e     = plan[j];
      e.imm = imm_of(op);
      if (plan_br[j]) e.pcw = taken(f3, zero, neg);
      exp_o = e;
      chk   = 1'b1;
      if (j == abort) begin
        rst     = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
  endtask

  logic [6:0] ops[8];
  logic [6:0] pin_op[9];
  int         pin_len[9];

  initial begin
    bit   ab;
    int   mw0;
    int   sel;
    int   abort_at;
    logic [6:0] op;

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    pin_op  = '{7'b1100011, 7'b0110011, 7'b0010011, 7'b0100011, 7'b0110111,
                7'b1101111, 7'b0000011, 7'b1100111, 7'b1111111};
    pin_len = '{3, 4, 4, 4, 3, 4, 5, 5, 2};
    for (int i = 0; i < 9; i++) begin
      build(pin_op[i]);
      tests++;
      if (plan.size() != pin_len[i]) begin
        fails++;
        $display("FAIL model_len op=%b got=%0d required=%0d", pin_op[i], plan.size(), pin_len[i]);
      end
    end
    tests++;
    if (imm_of(7'b0110111) != 3'b100) begin
      fails++;
      $display("FAIL model_imm_lui got=%b required=100", imm_of(7'b0110111));
    end

    apply_reset(3);

    run_instr(7'b0110011, 3'b000, -1, 0, 0, 0, ab);
    run_instr(7'b0000011, 3'b010, -1, 0, 0, 0, ab);
    mw0 = mw_pulses;
    run_instr(7'b0100011, 3'b010, -1, 0, 0, 0, ab);
    run_instr(7'b1100011, 3'b000, -1, 1, 1, 0, ab);
    tests++;
    if (mw_pulses - mw0 != 1) begin
      fails++;
      $display("FAIL sw_memwrite_count got=%0d required=1", mw_pulses - mw0);
    end
    run_instr(7'b1100011, 3'b000, -1, 1, 0, 0, ab);
    run_instr(7'b1100011, 3'b101, -1, 1, 0, 1, ab);
    run_instr(7'b1100011, 3'b010, -1, 1, 1, 1, ab);
    run_instr(7'b1101111, 3'b000, -1, 0, 0, 0, ab);
    run_instr(7'b1100111, 3'b000, -1, 0, 0, 0, ab);
    run_instr(7'b0110111, 3'b000, -1, 0, 0, 0, ab);
    run_instr(7'b1111111, 3'b000, -1, 0, 0, 0, ab);

    mw0 = mw_pulses;
    run_instr(7'b0100011, 3'b010, 3, 0, 0, 0, ab);
    apply_reset(2);
    run_instr(7'b0110011, 3'b000, -1, 0, 0, 0, ab);
    tests++;
    if (mw_pulses - mw0 != 1) begin
      fails++;
      $display("FAIL reset_in_memwrite_count got=%0d required=1", mw_pulses - mw0);
    end

    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       op = ops[sel];
      else if (sel == 8) op = 7'($urandom);
      else               op = 7'b1111111;
      build(op);
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, plan.size() - 1) : -1;
      run_instr(op, 3'($urandom), abort_at, 0, 0, 0, ab);
      if (ab) apply_reset($urandom_range(1, 3));
    end

    next_cycle(0, 0, 0);
    chk = 1'b0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
